// File: rtl/data_mem_sized.sv
// Byte-addressed data memory with byte/half/word access, configurable endianness,
// registered read port (read-first on collision) and sticky access-error capture.
module data_mem_sized #(
   parameter int DEPTH_BYTES = 1024,
   parameter int ADDR_W      = 32,
   parameter bit BIG_ENDIAN  = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] dir,
   input  logic [31:0]       writedato,
   input  logic              writeEN,
   input  logic              MemRead,
   input  logic [1:0]        size,
   input  logic              unsigned_ld,
   output logic [31:0]       dato,
   output logic              dato_valid,
   output logic              mem_err,
   output logic              err_sticky,
   output logic [ADDR_W-1:0] err_addr,
   input  logic              err_clr
);

   localparam int LA = $clog2(DEPTH_BYTES);
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH_BYTES);

   logic [7:0]        r_mem [DEPTH_BYTES];
   logic [31:0]       r_dato;
   logic              r_dato_valid;
   logic              r_mem_err;
   logic              r_err_sticky;
   logic [ADDR_W-1:0] r_err_addr;

   logic [1:0]        w_span;
   logic [ADDR_W:0]   w_last;
   logic              w_bad;
   logic              w_err;
   logic              w_do_wr;
   logic [LA-1:0]     w_idx [4];
   logic [7:0]        w_rb  [4];
   logic [7:0]        w_wb  [4];
   logic [3:0]        w_we;
   logic [31:0]       w_raw;
   logic [31:0]       w_load;

   // Range check is done one bit wider than the address so dir near the top
   // of the address space cannot wrap back into range.
   always_comb begin
      w_span = 2'd0;
      case (size)
         2'b00:   w_span = 2'd0;
         2'b01:   w_span = 2'd1;
         default: w_span = 2'd3;
      endcase
      w_last = {1'b0, dir} + {{(ADDR_W-1){1'b0}}, w_span};
      w_bad  = (size == 2'b11)
             | ((size == 2'b01) & dir[0])
             | ((size == 2'b10) & (dir[1:0] != 2'b00))
             | (w_last >= DEPTH_EXT);
      w_err  = (writeEN | MemRead) & w_bad;
      // A reset level present at the clock edge aborts the store.
      w_do_wr = writeEN & ~w_bad & ~rst;
   end

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         w_idx[k] = dir[LA-1:0] + LA'(k);
         w_rb[k]  = r_mem[w_idx[k]];
      end
   end

   // Store lane steering: lane k is the byte at dir+k.
   always_comb begin
      for (int k = 0; k < 4; k++) w_wb[k] = 8'h00;
      w_we = 4'b0000;
      case (size)
         2'b00: begin
            w_we    = 4'b0001;
            w_wb[0] = writedato[7:0];
         end
         2'b01: begin
            w_we    = 4'b0011;
            w_wb[0] = BIG_ENDIAN ? writedato[15:8] : writedato[7:0];
            w_wb[1] = BIG_ENDIAN ? writedato[7:0]  : writedato[15:8];
         end
         default: begin
            w_we    = 4'b1111;
            w_wb[0] = BIG_ENDIAN ? writedato[31:24] : writedato[7:0];
            w_wb[1] = BIG_ENDIAN ? writedato[23:16] : writedato[15:8];
            w_wb[2] = BIG_ENDIAN ? writedato[15:8]  : writedato[23:16];
            w_wb[3] = BIG_ENDIAN ? writedato[7:0]   : writedato[31:24];
         end
      endcase
   end

   always_comb begin
      w_raw  = 32'h0;
      w_load = 32'h0;
      case (size)
         2'b00:   w_raw = {24'h0, w_rb[0]};
         2'b01:   w_raw = BIG_ENDIAN ? {16'h0, w_rb[0], w_rb[1]}
                                     : {16'h0, w_rb[1], w_rb[0]};
         default: w_raw = BIG_ENDIAN ? {w_rb[0], w_rb[1], w_rb[2], w_rb[3]}
                                     : {w_rb[3], w_rb[2], w_rb[1], w_rb[0]};
      endcase
      case (size)
         2'b00:   w_load = unsigned_ld ? {24'h0, w_raw[7:0]}
                                       : {{24{w_raw[7]}}, w_raw[7:0]};
         2'b01:   w_load = unsigned_ld ? {16'h0, w_raw[15:0]}
                                       : {{16{w_raw[15]}}, w_raw[15:0]};
         default: w_load = w_raw;
      endcase
   end

   // Storage has no reset; contents survive rst.
   always_ff @(posedge clk) begin
      if (w_do_wr) begin
         for (int k = 0; k < 4; k++) begin
            if (w_we[k]) r_mem[w_idx[k]] <= w_wb[k];
         end
      end
   end

   // dato_valid and mem_err are single-cycle pulses with no ready/backpressure:
   // the consumer must take dato in the cycle dato_valid is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dato       <= 32'h0;
         r_dato_valid <= 1'b0;
         r_mem_err    <= 1'b0;
         r_err_sticky <= 1'b0;
         r_err_addr   <= '0;
      end else begin
         r_dato_valid <= MemRead;
         r_mem_err    <= w_err;
         if (MemRead) r_dato <= w_bad ? 32'h0 : w_load;
         if (w_err) begin
            r_err_sticky <= 1'b1;
            r_err_addr   <= dir;
         end else if (err_clr) begin
            r_err_sticky <= 1'b0;
         end
      end
   end

   assign dato       = r_dato;
   assign dato_valid = r_dato_valid;
   assign mem_err    = r_mem_err;
   assign err_sticky = r_err_sticky;
   assign err_addr   = r_err_addr;

endmodule

// File: doc/data_mem_sized.md
Name: data_mem_sized

Overview:
Byte-addressed data memory with parametrised depth and endianness, and a synchronous, registered read port.
- Supports byte, halfword and word loads/stores; sub-word loads are sign- or zero-extended.
- Detects misaligned, out-of-range and reserved-size accesses and records them in sticky error registers.
- Sits in the MEM stage of the processor datapath as the next-generation data memory, driven by ALU address and register-file store data.

Parameters:
DEPTH_BYTES, 1024, number of bytes of storage; must be a power of two, >= 4.
ADDR_W, 32, width of the address input; address bits above log2(DEPTH_BYTES) take part in the range check.
BIG_ENDIAN, 1, 1: byte at dir is the MSB of the halfword/word; 0: byte at dir is the LSB.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
dir  in  ADDR_W  byte address of the access.
writedato  in  32  store data, right-aligned: byte uses [7:0], half uses [15:0], word uses [31:0].
writeEN  in  1  store request, sampled on rising clk.
MemRead  in  1  load request, sampled on rising clk.
size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
unsigned_ld  in  1  1 = zero-extend sub-word load; 0 = sign-extend.
dato  out  32  registered load data.
dato_valid  out  1  one-cycle pulse, the cycle after a load request.
mem_err  out  1  one-cycle pulse, the cycle after an erroneous access.
err_sticky  out  1  set by any erroneous access; held until err_clr.
err_addr  out  ADDR_W  dir of the most recent erroneous access.
err_clr  in  1  synchronous clear of err_sticky.

Behaviour:
- Reset (async, rst=1):
  - dato=0, dato_valid=0, mem_err=0, err_sticky=0, err_addr=0.
  - Memory array is NOT cleared.
  - Reset asserted mid-access aborts it: no write commits on that edge, and no dato_valid follows.
- Access error (bad) when any of the following holds:
  - size==11;
  - size==01 and dir[0]!=0;
  - size==10 and dir[1:0]!=0;
  - dir + nbytes - 1 >= DEPTH_BYTES, evaluated on the full ADDR_W value, where nbytes is 1, 2 or 4.
- Store (writeEN=1, not bad): on the rising edge, nbytes bytes are written starting at dir, ordered per BIG_ENDIAN.
  - Big-endian word: mem[dir]=wd[31:24], mem[dir+1]=wd[23:16], mem[dir+2]=wd[15:8], mem[dir+3]=wd[7:0].
  - Half and byte follow the same pattern using wd[15:0] and wd[7:0].
  - Unaddressed bytes are unchanged.
- Erroneous store: memory is unchanged and the error is reported.
- Load (MemRead=1), latency 1 cycle:
  - On edge N, dato is loaded with the assembled and extended value; dato_valid=1 during cycle N+1.
  - Sign extension replicates bit 7 (byte) or bit 15 (half) unless unsigned_ld=1.
- Erroneous load: dato=0 with dato_valid=1 and the error reported.
- Without MemRead, dato holds its previous value and dato_valid=0.
- writeEN and MemRead both high: the store executes and the load returns the PRE-write contents (read-first). A single error check covers both.
- Error reporting on edge N: mem_err=1 during cycle N+1, err_sticky<=1, err_addr<=dir.
- err_clr=1 with no new error: err_sticky<=0 and err_addr holds. If a new error occurs in the same cycle, the set wins.
- Idle (neither request): no state change except err_clr.
- Back-to-back loads on consecutive cycles give a dato_valid pulse on every cycle, with no bubble.

Test Plan:
1. Word round trip: store 0xDEADBEEF at 0x10 (word); byte load at 0x10 signed -> 0xFFFFFFDE; byte load at 0x13 unsigned -> 0x000000EF; word load at 0x10 -> 0xDEADBEEF, dato_valid exactly 1 cycle after each MemRead.
2. Sub-word stores: store half 0x8001 at 0x20, then byte 0x7F at 0x23; word load at 0x20 -> 0x8001xx7F with byte 0x22 unchanged; half load 0x20 signed -> 0xFFFF8001, unsigned -> 0x00008001.
3. Errors: word load at 0x21 -> dato=0, dato_valid=1, mem_err=1, err_addr=0x21; word store at 0x3FE with DEPTH_BYTES=1024 -> memory unchanged, err_sticky=1; size=11 -> error. Then err_clr -> err_sticky=0.
4. Read-first collision: mem[0x40..43]=0x11223344; same cycle store word 0xAABBCCDD and load 0x40 -> dato=0x11223344; next load -> 0xAABBCCDD.
5. Reset mid-operation: assert rst asynchronously between clk edges while writeEN=1 for 0x50 -> outputs 0 immediately, no dato_valid, 0x50 keeps its old contents; prior memory data is still readable after reset.
6. BIG_ENDIAN=0 instance: store word 0x01020304 at 0 -> byte load 0 = 0x04, byte load 3 = 0x01; back-to-back loads on 4 cycles -> 4 consecutive dato_valid pulses.
